jtag_scan_master: RTL and testbench

- Host-side JTAG TAP driver that generates TCK/TMS/TDI and samples TDO, so the fabric can drive the team's virtual-JTAG responder (opcodes IDCODE, READREG, SETREGISTER, RESETHI/RESETLO, ...) or any 1149.1 TAP.
- Accepts IR-scan, DR-scan, idle-cycle and TAP-reset commands over a valid/ready interface.
- Returns captured TDO bits on a one-cycle response strobe.
- Sits between a test sequencer and the board JTAG pins, or a loopback into a TAP model.

---
 rtl/jtag_host_pkg.sv | 50 +++++
 rtl/jtag_tck_gen.sv | 44 ++++
 rtl/jtag_scan_master.sv | 175 +++++++++++++++++
 tb/tb_jtag_scan_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - shared JTAG host command/state types, TMS sequences and responder opcodes
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET   = 2'd0,
        OP_IR_SCAN     = 2'd1,
        OP_DR_SCAN     = 2'd2,
        OP_IDLE_CYCLES = 2'd3
    } cmd_op_e;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_READY,
        ST_RESET_WALK,
        ST_SEL_DR,
        ST_SEL_IR,
        ST_CAPTURE,
        ST_SHIFT,
        ST_EXIT1,
        ST_UPDATE,
        ST_RTI,
        ST_IDLE_RUN,
        ST_DONE
    } jtag_state_e;

    // TMS sequences around the shift phase, bit0 is driven first
    localparam logic [5:0] TMS_RESET_WALK = 6'b01_1111;
    localparam logic [3:0] TMS_IR_PREFIX  = 4'b0011;
    localparam logic [2:0] TMS_DR_PREFIX  = 3'b001;
    localparam logic [1:0] TMS_SUFFIX     = 2'b01;

    localparam int RESET_WALK_ONES = 5;
    localparam int CAPTURE_TICKS   = 2;

    localparam logic [3:0] OPC_IDCODE      = 4'b0001;
    localparam logic [3:0] OPC_READREG     = 4'b0010;
    localparam logic [3:0] OPC_SETREGISTER = 4'b0011;
    localparam logic [3:0] OPC_WRITEREG    = 4'b0111;
    localparam logic [3:0] OPC_RESETHI     = 4'b1011;
    localparam logic [3:0] OPC_RESETLO     = 4'b1100;
    localparam logic [3:0] OPC_BYPASS      = 4'b1111;

    function automatic logic [5:0] clamp_len(input logic [5:0] len, input int max_len);
        if (int'(len) > max_len) begin
            return 6'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider: low then high for TCK_DIV clks each, with rise/fall strobes
module jtag_tck_gen
    import jtag_host_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_tick_rise,
    output logic o_tick_fall
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
    localparam logic [CW-1:0] RISE_AT = CW'(TCK_DIV - 1);
    localparam logic [CW-1:0] FALL_AT = CW'(2 * TCK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == FALL_AT) ? '0 : r_cnt + 1'b1;
            if (r_cnt == RISE_AT) begin
                r_tck <= 1'b1;
            end else if (r_cnt == FALL_AT) begin
                r_tck <= 1'b0;
            end
        end
    end

    // Strobes mark the clk edge on which tck changes level
    assign o_tick_rise = i_en && (r_cnt == RISE_AT);
    assign o_tick_fall = i_en && (r_cnt == FALL_AT);
    assign o_tck       = r_tck;

endmodule

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG TAP host: TAP reset, IR/DR scans and idle ticks from a command port
module jtag_scan_master
    import jtag_host_pkg::*;
#(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               notReset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    jtag_state_e        r_state, w_state_nxt;
    cmd_op_e            r_op, w_op_nxt;
    logic [5:0]         r_len, w_len_nxt;
    logic [5:0]         r_tick, w_tick_nxt;
    logic [MAX_LEN-1:0] r_data, w_data_nxt;
    logic [MAX_LEN-1:0] r_cap, w_cap_nxt;
    logic [MAX_LEN-1:0] r_rsp;
    logic               r_init, w_init_nxt;
    logic               r_tms, w_tms_nxt;
    logic               r_tdi, w_tdi_nxt;

    logic               w_idle;
    logic               w_tick_en;
    logic               w_tick_rise;
    logic               w_tick_fall;
    logic [5:0]         w_len_clamped;
    logic [MAX_LEN-1:0] w_bit;
    logic [MAX_LEN-1:0] w_sh;

    assign w_idle        = (r_state == ST_READY) || (r_state == ST_DONE);
    assign w_tick_en     = !w_idle && (r_state != ST_INIT);
    assign w_len_clamped = clamp_len(cmd_len, MAX_LEN);
    assign w_bit         = MAX_LEN'(1) << r_tick;

    assign cmd_ready = w_idle;
    assign busy      = !w_idle;
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_data  = r_rsp;
    assign tms       = r_tms;
    assign tdi       = r_tdi;

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk         (clk),
        .rst_n       (notReset),
        .i_en        (w_tick_en),
        .o_tck       (tck),
        .o_tick_rise (w_tick_rise),
        .o_tick_fall (w_tick_fall)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_len_nxt   = r_len;
        w_tick_nxt  = r_tick;
        w_data_nxt  = r_data;
        w_cap_nxt   = r_cap;
        w_init_nxt  = r_init;

        if (w_tick_rise && (r_state == ST_SHIFT) && tdo) begin
            w_cap_nxt = r_cap | w_bit;
        end

        unique case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_RESET_WALK;
            end
            ST_READY, ST_DONE: begin
                w_state_nxt = ST_READY;
                if (cmd_valid) begin
                    w_op_nxt   = cmd_op_e'(cmd_op);
                    w_len_nxt  = w_len_clamped;
                    w_data_nxt = cmd_data;
                    w_cap_nxt  = '0;
                    case (cmd_op_e'(cmd_op))
                        OP_TAP_RESET:   w_state_nxt = ST_RESET_WALK;
                        OP_IDLE_CYCLES: w_state_nxt = (w_len_clamped == 6'd0) ? ST_DONE : ST_IDLE_RUN;
                        default:        w_state_nxt = (w_len_clamped == 6'd0) ? ST_DONE : ST_SEL_DR;
                    endcase
                end
            end
            default: begin
                // Every tick-consuming state only advances on the falling edge of tck
                if (w_tick_fall) begin
                    w_tick_nxt = r_tick + 6'd1;
                    case (r_state)
                        ST_RESET_WALK: if (r_tick == 6'(RESET_WALK_ONES - 1)) w_state_nxt = ST_RTI;
                        ST_RTI: begin
                            w_state_nxt = r_init ? ST_READY : ST_DONE;
                            w_init_nxt  = 1'b0;
                        end
                        ST_SEL_DR:     w_state_nxt = (r_op == OP_IR_SCAN) ? ST_SEL_IR : ST_CAPTURE;
                        ST_SEL_IR:     w_state_nxt = ST_CAPTURE;
                        ST_CAPTURE:    if (r_tick == 6'(CAPTURE_TICKS - 1)) w_state_nxt = ST_SHIFT;
                        ST_SHIFT:      if (r_tick == r_len - 6'd1) w_state_nxt = ST_EXIT1;
                        ST_EXIT1:      w_state_nxt = ST_UPDATE;
                        ST_UPDATE:     w_state_nxt = ST_DONE;
                        ST_IDLE_RUN:   if (r_tick == r_len - 6'd1) w_state_nxt = ST_DONE;
                        default:       w_state_nxt = ST_READY;
                    endcase
                end
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_tick_nxt = '0;
        end
    end

    // Pin values are computed for the upcoming tick and only move at tick boundaries
    always_comb begin
        w_sh      = w_data_nxt >> w_tick_nxt;
        w_tms_nxt = 1'b0;
        w_tdi_nxt = 1'b0;
        unique case (w_state_nxt)
            ST_INIT:       w_tms_nxt = 1'b1;
            ST_RESET_WALK: w_tms_nxt = TMS_RESET_WALK[0];
            ST_RTI:        w_tms_nxt = TMS_RESET_WALK[5];
            ST_SEL_DR:     w_tms_nxt = TMS_DR_PREFIX[0];
            ST_SEL_IR:     w_tms_nxt = TMS_IR_PREFIX[1];
            ST_CAPTURE:    w_tms_nxt = TMS_DR_PREFIX[1];
            ST_SHIFT: begin
                w_tms_nxt = (w_tick_nxt == w_len_nxt - 6'd1);
                w_tdi_nxt = w_sh[0];
            end
            ST_EXIT1:      w_tms_nxt = TMS_SUFFIX[0];
            ST_UPDATE:     w_tms_nxt = TMS_SUFFIX[1];
            default:       w_tms_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            r_state <= ST_INIT;
            r_op    <= OP_TAP_RESET;
            r_len   <= '0;
            r_tick  <= '0;
            r_data  <= '0;
            r_cap   <= '0;
            r_rsp   <= '0;
            r_init  <= 1'b1;
            r_tms   <= 1'b1;
            r_tdi   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_len   <= w_len_nxt;
            r_tick  <= w_tick_nxt;
            r_data  <= w_data_nxt;
            r_cap   <= w_cap_nxt;
            r_init  <= w_init_nxt;
            r_tms   <= w_tms_nxt;
            r_tdi   <= w_tdi_nxt;
            if (w_state_nxt == ST_DONE) begin
                r_rsp <= w_cap_nxt;
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - directed bench with a TAP model, loopback path and response scoreboard
module tb_jtag_scan_master;

    localparam logic [31:0] IDCODE_VAL = 32'h1000_11d3;
    localparam logic [4:0]  IR_CAPTURE = 5'b10101;

    logic        clk = 1'b0;
    logic        notReset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;

    int          checks = 0;
    int          failures = 0;
    int          rises = 0;
    int          rsp_count = 0;
    int          snap;
    logic [63:0] tms_log = '0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR,
        T_UDR, T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
    } tap_e;

    tap_e        tap_st;
    logic [31:0] dr_sh;
    logic [4:0]  ir_sh;
    logic [4:0]  ir_reg;
    logic        tap_tdo = 1'b0;
    logic        lb_q = 1'b0;
    logic        sel_lb = 1'b0;

    assign tdo = sel_lb ? lb_q : tap_tdo;

    jtag_scan_master #(
        .TCK_DIV (2),
        .MAX_LEN (32)
    ) dut (
        .clk       (clk),
        .notReset  (notReset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    always @(posedge tck or negedge notReset) begin
        if (!notReset) begin
            tap_st <= T_TLR;
            ir_reg <= {1'b0, jtag_host_pkg::OPC_IDCODE};
            ir_sh  <= '0;
            dr_sh  <= '0;
        end else begin
            case (tap_st)
                T_TLR:  tap_st <= tms ? T_TLR  : T_RTI;
                T_RTI:  tap_st <= tms ? T_SDR  : T_RTI;
                T_SDR:  tap_st <= tms ? T_SIR  : T_CDR;
                T_CDR:  tap_st <= tms ? T_E1DR : T_SHDR;
                T_SHDR: tap_st <= tms ? T_E1DR : T_SHDR;
                T_E1DR: tap_st <= tms ? T_UDR  : T_PDR;
                T_PDR:  tap_st <= tms ? T_E2DR : T_PDR;
                T_E2DR: tap_st <= tms ? T_UDR  : T_SHDR;
                T_UDR:  tap_st <= tms ? T_SDR  : T_RTI;
                T_SIR:  tap_st <= tms ? T_TLR  : T_CIR;
                T_CIR:  tap_st <= tms ? T_E1IR : T_SHIR;
                T_SHIR: tap_st <= tms ? T_E1IR : T_SHIR;
                T_E1IR: tap_st <= tms ? T_UIR  : T_PIR;
                T_PIR:  tap_st <= tms ? T_E2IR : T_PIR;
                T_E2IR: tap_st <= tms ? T_UIR  : T_SHIR;
                default: tap_st <= tms ? T_SDR : T_RTI;
            endcase
            if (tap_st == T_TLR)  ir_reg <= {1'b0, jtag_host_pkg::OPC_IDCODE};
            if (tap_st == T_CDR)  dr_sh  <= (ir_reg == 5'd1) ? IDCODE_VAL : 32'h0;
            if (tap_st == T_SHDR) dr_sh  <= {tdi, dr_sh[31:1]};
            if (tap_st == T_CIR)  ir_sh  <= IR_CAPTURE;
            if (tap_st == T_SHIR) ir_sh  <= {tdi, ir_sh[4:1]};
            if (tap_st == T_UIR)  ir_reg <= ir_sh;
        end
    end

    always @(negedge tck) begin
        tap_tdo <= (tap_st == T_SHDR) ? dr_sh[0] : (tap_st == T_SHIR) ? ir_sh[0] : 1'b0;
    end

    always @(posedge tck) begin
        lb_q <= tdi;
        if (rises < 64) tms_log[rises] = tms;
        rises = rises + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_count = rsp_count + 1;
            chk("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_val = exp_q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(exp_val));
            end
        end
    end

    function automatic logic [63:0] exp_tms(input logic is_ir, input int n);
        logic [63:0] v;
        int p;
        v = '0;
        v[0] = 1'b1;
        p = 1;
        if (is_ir) begin
            v[1] = 1'b1;
            p = 2;
        end
        p = p + 2 + n - 1;
        v[p] = 1'b1;
        v[p + 1] = 1'b1;
        return v;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        @(negedge clk);
        rises = 0;
        tms_log = '0;
        cmd_op = op;
        cmd_len = len;
        cmd_data = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int n0);
        int i;
        i = 0;
        while (rsp_count == n0 && i < 3000) begin
            @(negedge clk);
            i = i + 1;
        end
        chk(tag, 64'(rsp_count - n0), 64'd1);
    endtask

    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        while (!cmd_ready && i < 3000) begin
            @(negedge clk);
            i = i + 1;
        end
        chk(tag, {63'd0, cmd_ready}, 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_pins", {58'd0, tck, tms, tdi, cmd_ready, rsp_valid, busy}, 64'b010001);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);

        rises = 0;
        tms_log = '0;
        notReset = 1'b1;
        wait_ready("init_ready");
        chk("init_rises", 64'(rises), 64'd6);
        chk("init_tms", tms_log, 64'h1F);
        chk("init_busy", {63'd0, busy}, 64'd0);
        chk("init_no_rsp", 64'(rsp_count), 64'd0);

        snap = rsp_count;
        exp_q.push_back({27'd0, IR_CAPTURE});
        issue(2'd1, 6'd5, 32'h01);
        wait_rsp("ir_done", snap);
        chk("ir_rises", 64'(rises), 64'd11);
        chk("ir_tms", tms_log, exp_tms(1'b1, 5));
        chk("ir_model", 64'(ir_reg), 64'd1);

        snap = rsp_count;
        exp_q.push_back(IDCODE_VAL);
        issue(2'd2, 6'd32, 32'h0);
        wait_rsp("idcode_done", snap);
        chk("idcode_rises", 64'(rises), 64'd37);
        chk("idcode_tms", tms_log, exp_tms(1'b0, 32));

        sel_lb = 1'b1;
        snap = rsp_count;
        exp_q.push_back(32'hA5A5_A5A5 << 1);
        issue(2'd2, 6'd40, 32'hA5A5_A5A5);
        wait_rsp("clamp_done", snap);
        chk("clamp_rises", 64'(rises), 64'd37);

        @(negedge clk);
        snap = rsp_count;
        rises = 0;
        cmd_op = 2'd3;
        cmd_len = 6'd0;
        cmd_data = 32'hFFFF_FFFF;
        cmd_valid = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("len0_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("len0_ready", {63'd0, cmd_ready}, 64'd1);
        exp_q.push_back(32'h3C << 1);
        cmd_op = 2'd2;
        cmd_len = 6'd8;
        cmd_data = 32'h3C;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("len0_next_accepted", {62'd0, cmd_ready, busy}, 64'b01);
        chk("len0_no_tck", 64'(rises), 64'd0);
        wait_rsp("dr8_done", snap + 1);
        chk("dr8_rises", 64'(rises), 64'd13);

        sel_lb = 1'b0;
        issue(2'd2, 6'd32, 32'hFFFF_0000);
        begin
            int i;
            i = 0;
            while (rises < 14 && i < 3000) begin
                @(negedge clk);
                i = i + 1;
            end
        end
        chk("abort_reached_bit10", 64'(rises), 64'd14);
        snap = rsp_count;
        #1 notReset = 1'b0;
        #1;
        chk("abort_pins", {59'd0, tck, tms, cmd_ready, rsp_valid, busy}, 64'b01001);
        chk("abort_rsp_data", 64'(rsp_data), 64'd0);
        repeat (3) @(negedge clk);
        rises = 0;
        tms_log = '0;
        notReset = 1'b1;
        wait_ready("reinit_ready");
        chk("reinit_rises", 64'(rises), 64'd6);
        chk("reinit_tms", tms_log, 64'h1F);
        chk("abort_no_rsp", 64'(rsp_count - snap), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
